// File: rtl/crc32_pkg.sv
// Shared constants and FSM state type for the crc32_wide slice.
// Optional Adler-32 support is built only with CRC32W_ADLER_EN defined.
package crc32_pkg;

    localparam logic [31:0] CRC32_POLY   = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_INIT   = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_XOROUT = 32'hFFFF_FFFF;
    localparam logic [16:0] ADLER_MOD    = 17'd65521;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

`ifdef CRC32W_ADLER_EN
    localparam logic [31:0] ADLER_INIT = 32'h0000_0001;

    // Operands stay below 2*ADLER_MOD, so one conditional subtract reduces them.
    function automatic logic [31:0] adler_step(input logic [31:0] ba, input logic [7:0] d);
        logic [16:0] a;
        logic [16:0] b;
        a = {1'b0, ba[15:0]} + {9'd0, d};
        if (a >= ADLER_MOD) a = a - ADLER_MOD;
        b = {1'b0, ba[31:16]} + a;
        if (b >= ADLER_MOD) b = b - ADLER_MOD;
        return {b[15:0], a[15:0]};
    endfunction
`endif

endpackage

// File: rtl/crc32_byte.sv
// Combinational one-byte reflected CRC-32 update, LSB first.
// Used by crc32_wide; unaffected by CRC32W_ADLER_EN.
module crc32_byte
    import crc32_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  dat,
    output logic [31:0] nxt
);

    always_comb begin
        nxt = crc ^ {24'd0, dat};
        for (int unsigned i = 0; i < 8; i++) begin
            nxt = nxt[0] ? ((nxt >> 1) ^ CRC32_POLY) : (nxt >> 1);
        end
    end

endmodule

// File: rtl/crc32_wide.sv
// Multi-byte-per-beat CRC-32 engine with IDLE/BUSY/DONE message framing.
// Define CRC32W_ADLER_EN to add mode_i and an Adler-32 alternative.
module crc32_wide
    import crc32_pkg::*;
#(
    parameter int unsigned DAT_BYTES = 4,
    parameter int unsigned CNT_W     = $clog2(DAT_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic                   val_i,
    input  logic [8*DAT_BYTES-1:0] dat_i,
    input  logic [CNT_W-1:0]       cnt_i,
    input  logic                   lst_i,
`ifdef CRC32W_ADLER_EN
    input  logic                   mode_i,
`endif
    output logic                   rdy_o,
    output logic                   done_o,
    output logic                   val_o,
    output logic [31:0]            dat_o
);

    state_t                      state_q, state_d;
    logic                        beat_ok, last_ok;
    logic [31:0]                 acc_q, base, init_val, folded, result;
    logic [DAT_BYTES-1:0]        en;
    logic [DAT_BYTES:0][31:0]    crc_chain;
    logic [DAT_BYTES-1:0][31:0]  stage_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        rdy_o   = (state_q != DONE);
        beat_ok = val_i && ((state_q == BUSY) || ((state_q == IDLE) && start_i));
        last_ok = beat_ok && lst_i;
        state_d = state_q;
        case (state_q)
            DONE:    state_d = start_i ? BUSY : IDLE;
            BUSY:    state_d = last_ok ? DONE : BUSY;
            default: state_d = last_ok ? DONE : (start_i ? BUSY : IDLE);
        endcase
    end

    // Any cnt_i above DAT_BYTES enables every lane, which gives saturation for free.
    always_comb begin
        en = '0;
        for (int unsigned i = 0; i < DAT_BYTES; i++) begin
            en[i] = !lst_i || (32'(cnt_i) > i);
        end
    end

    assign base         = start_i ? init_val : acc_q;
    assign crc_chain[0] = base;

    for (genvar g = 0; g < DAT_BYTES; g++) begin : g_lane
        crc32_byte u_byte (
            .crc (crc_chain[g]),
            .dat (dat_i[8*g +: 8]),
            .nxt (stage_out[g])
        );
        assign crc_chain[g+1] = en[g] ? stage_out[g] : crc_chain[g];
    end

`ifdef CRC32W_ADLER_EN
    logic        mode_q, mode_eff;
    logic [31:0] adler_fold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          mode_q <= 1'b0;
        else if (start_i) mode_q <= mode_i;
    end

    assign mode_eff = start_i ? mode_i : mode_q;

    always_comb begin
        adler_fold = base;
        for (int unsigned i = 0; i < DAT_BYTES; i++) begin
            if (en[i]) adler_fold = adler_step(adler_fold, dat_i[8*i +: 8]);
        end
    end

    assign init_val = mode_eff ? ADLER_INIT : CRC32_INIT;
    assign folded   = mode_eff ? adler_fold : crc_chain[DAT_BYTES];
    assign result   = mode_eff ? folded : (folded ^ CRC32_XOROUT);
`else
    assign init_val = CRC32_INIT;
    assign folded   = crc_chain[DAT_BYTES];
    assign result   = folded ^ CRC32_XOROUT;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= CRC32_INIT;
            done_o <= 1'b0;
            val_o  <= 1'b0;
            dat_o  <= '0;
        end else begin
            if (beat_ok)      acc_q <= folded;
            else if (start_i) acc_q <= init_val;
            done_o <= last_ok;
            if (last_ok) begin
                dat_o <= result;
                val_o <= 1'b1;
            end else if (start_i) begin
                val_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_crc32_wide.sv
// Directed self-checking bench for crc32_wide at DAT_BYTES=1 and DAT_BYTES=4.
// Adler-32 vectors are included when CRC32W_ADLER_EN is defined.
module tb_crc32_wide;

    localparam logic [31:0] W_IEND = 32'h444E_4549;
    localparam logic [31:0] W_1234 = 32'h3433_3231;
    localparam logic [31:0] W_5678 = 32'h3837_3635;

    logic        clk = 1'b0;
    logic        rst;

    logic        s1, v1, l1, c1, m1;
    logic [7:0]  d1;
    logic        r1, dn1, vo1;
    logic [31:0] q1;

    logic        s4, v4, l4, m4;
    logic [2:0]  c4;
    logic [31:0] d4;
    logic        r4, dn4, vo4;
    logic [31:0] q4;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned n_done4 = 0;
    int unsigned n0;

    always #5 clk = ~clk;

    crc32_wide #(.DAT_BYTES(1)) u_dut1 (
        .clk(clk), .rst(rst), .start_i(s1), .val_i(v1), .dat_i(d1), .cnt_i(c1), .lst_i(l1),
`ifdef CRC32W_ADLER_EN
        .mode_i(m1),
`endif
        .rdy_o(r1), .done_o(dn1), .val_o(vo1), .dat_o(q1)
    );

    crc32_wide #(.DAT_BYTES(4)) u_dut4 (
        .clk(clk), .rst(rst), .start_i(s4), .val_i(v4), .dat_i(d4), .cnt_i(c4), .lst_i(l4),
`ifdef CRC32W_ADLER_EN
        .mode_i(m4),
`endif
        .rdy_o(r4), .done_o(dn4), .val_o(vo4), .dat_o(q4)
    );

    always @(negedge clk) if (dn4) n_done4++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic beat1(input logic s, input logic v, input logic l, input logic c, input logic [7:0] d);
        s1 = s; v1 = v; l1 = l; c1 = c; d1 = d;
        @(posedge clk); #1;
        s1 = 1'b0; v1 = 1'b0; l1 = 1'b0;
    endtask

    task automatic beat4(input logic s, input logic v, input logic l, input logic [2:0] c, input logic [31:0] d);
        s4 = s; v4 = v; l4 = l; c4 = c; d4 = d;
        @(posedge clk); #1;
        s4 = 1'b0; v4 = 1'b0; l4 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        s1 = 0; v1 = 0; l1 = 0; c1 = 0; d1 = '0; m1 = 0;
        s4 = 0; v4 = 0; l4 = 0; c4 = '0; d4 = '0; m4 = 0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_done", dn4, 0);
        check_eq("rst_val", vo4, 0);
        check_eq("rst_dat", q4, 32'h0);
        check_eq("rst_rdy", r4, 1);
        check_eq("rst_rdy1", r1, 1);
        rst = 1'b0;
        @(posedge clk); #1;

        // One byte per beat: "123456789".
        for (int i = 0; i < 8; i++) beat1(i == 0, 1'b1, 1'b0, 1'b1, 8'(8'h31 + i));
        check_eq("b1_no_early_done", dn1, 0);
        beat1(1'b0, 1'b1, 1'b1, 1'b1, 8'h39);
        check_eq("b1_done", dn1, 1);
        check_eq("b1_crc", q1, 32'hCBF4_3926);
        check_eq("b1_val", vo1, 1);
        check_eq("b1_rdy_in_done", r1, 0);
        @(posedge clk); #1;
        check_eq("b1_done_pulse", dn1, 0);
        check_eq("b1_val_held", vo1, 1);

        // Four bytes per beat.
        beat4(1'b1, 1'b1, 1'b1, 3'd4, W_IEND);
        check_eq("iend_done", dn4, 1);
        check_eq("iend_crc", q4, 32'hAE42_6082);
        @(posedge clk); #1;

        beat4(1'b1, 1'b1, 1'b0, 3'd4, W_1234);
        check_eq("start_clr_val", vo4, 0);
        beat4(1'b0, 1'b1, 1'b0, 3'd4, W_5678);
        beat4(1'b0, 1'b1, 1'b1, 3'd1, 32'hAABB_CC39);
        check_eq("crc9_partial", q4, 32'hCBF4_3926);
        check_eq("crc9_done", dn4, 1);
        @(posedge clk); #1;

        beat4(1'b1, 1'b1, 1'b1, 3'd0, 32'hDEAD_BEEF);
        check_eq("empty_crc", q4, 32'h0);
        check_eq("empty_val", vo4, 1);
        check_eq("empty_done", dn4, 1);
        @(posedge clk); #1;

        beat4(1'b1, 1'b1, 1'b1, 3'd7, W_IEND);
        check_eq("sat_crc", q4, 32'hAE42_6082);
        beat4(1'b0, 1'b1, 1'b1, 3'd4, 32'h1234_5678);
        check_eq("done_beat_ignored", dn4, 0);
        check_eq("done_beat_dat", q4, 32'hAE42_6082);
        beat4(1'b0, 1'b1, 1'b1, 3'd4, 32'h1234_5678);
        check_eq("idle_beat_ignored", dn4, 0);
        check_eq("idle_beat_val", vo4, 1);

        // Abort: restart mid-"123456789", then a full "IEND".
        beat4(1'b1, 1'b1, 1'b0, 3'd4, W_1234);
        beat4(1'b0, 1'b1, 1'b0, 3'd4, W_5678);
        n0 = n_done4;
        beat4(1'b1, 1'b1, 1'b1, 3'd4, W_IEND);
        check_eq("abort_crc", q4, 32'hAE42_6082);
        @(posedge clk); #1;
        check_eq("abort_one_done", 32'(n_done4 - n0), 32'd1);

        // Start during the DONE cycle.
        beat4(1'b1, 1'b1, 1'b1, 3'd4, W_IEND);
        check_eq("sid_done", dn4, 1);
        beat4(1'b1, 1'b0, 1'b0, 3'd0, 32'h0);
        check_eq("sid_val_clr", vo4, 0);
        check_eq("sid_no_done", dn4, 0);
        check_eq("sid_rdy", r4, 1);
        beat4(1'b0, 1'b1, 1'b0, 3'd4, W_1234);
        beat4(1'b0, 1'b1, 1'b0, 3'd4, W_5678);
        beat4(1'b0, 1'b1, 1'b1, 3'd1, 32'h0000_0039);
        check_eq("sid_crc", q4, 32'hCBF4_3926);
        @(posedge clk); #1;

        // Asynchronous reset mid-message.
        beat4(1'b1, 1'b1, 1'b0, 3'd4, W_1234);
        beat4(1'b0, 1'b1, 1'b0, 3'd4, W_5678);
        n0 = n_done4;
        #2 rst = 1'b1;
        #1;
        check_eq("arst_dat", q4, 32'h0);
        check_eq("arst_val", vo4, 0);
        check_eq("arst_rdy", r4, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        beat4(1'b0, 1'b1, 1'b1, 3'd4, W_IEND);
        @(posedge clk); #1;
        check_eq("arst_no_done", 32'(n_done4 - n0), 32'd0);
        check_eq("arst_val_after", vo4, 0);

`ifdef CRC32W_ADLER_EN
        // Mode is sampled on start only; later mode_i changes are ignored.
        m4 = 1'b1;
        beat4(1'b1, 1'b1, 1'b0, 3'd4, W_1234);
        m4 = 1'b0;
        beat4(1'b0, 1'b1, 1'b0, 3'd4, W_5678);
        beat4(1'b0, 1'b1, 1'b1, 3'd1, 32'hFFFF_FF39);
        check_eq("adler_sum", q4, 32'h091E_01DE);
        check_eq("adler_done", dn4, 1);
        @(posedge clk); #1;
        m4 = 1'b1;
        beat4(1'b1, 1'b1, 1'b1, 3'd0, 32'h0);
        m4 = 1'b0;
        check_eq("adler_empty", q4, 32'h0000_0001);
        @(posedge clk); #1;
        beat4(1'b1, 1'b1, 1'b1, 3'd4, W_IEND);
        check_eq("crc_after_adler", q4, 32'hAE42_6082);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/crc32_wide.md
CRC32_WIDE -- requirements
Module: crc32_wide

Interface
REQ-001 SHALL have parameter DAT_BYTES, default 4, meaning bytes per input beat; legal values 1, 2, 4, 8.
REQ-002 SHALL have parameter CNT_W, default $clog2(DAT_BYTES+1), meaning the width of cnt_i.
REQ-003 SHALL provide clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL provide rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL provide start_i, input, 1 bit: one-cycle pulse that opens a new message.
REQ-006 SHALL provide val_i, input, 1 bit: dat_i beat valid.
REQ-007 SHALL provide dat_i, input, 8*DAT_BYTES bits: message bytes; byte 0 = dat_i[7:0] is processed first.
REQ-008 SHALL provide cnt_i, input, CNT_W bits: valid bytes on the last beat, 0..DAT_BYTES; ignored when lst_i=0.
REQ-009 SHALL provide lst_i, input, 1 bit: qualifies the final beat of the message, sampled only with val_i=1.
REQ-010 SHALL provide rdy_o, output, 1 bit: beat accepted when val_i&rdy_o.
REQ-011 SHALL provide done_o, output, 1 bit: one-cycle pulse when the result is written.
REQ-012 SHALL provide val_o, output, 1 bit: level, result on dat_o valid.
REQ-013 SHALL provide dat_o, output, 32 bits: checksum result.
REQ-014 SHALL provide mode_i, input, 1 bit: 0 = CRC-32, 1 = Adler-32; present only with CRC32W_ADLER_EN.

Function
REQ-015 SHALL compute CRC-32 as reflected poly 0xEDB88320, init 0xFFFFFFFF, final XOR 0xFFFFFFFF, LSB-first per byte.
REQ-016 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-017 SHALL take these transitions: IDLE->BUSY on start_i; BUSY->DONE on accepted lst_i beat; DONE->IDLE after one cycle.
REQ-018 SHALL drive rdy_o=1 in IDLE and BUSY, and rdy_o=0 in DONE.
REQ-019 SHALL ignore beats presented in DONE.
REQ-020 SHALL load the accumulator with the init value on start_i.
REQ-021 SHALL treat a beat with val_i in the same cycle as start_i as the first beat of the new message.
REQ-022 SHALL ignore val_i in IDLE without start_i: no accumulator change.
REQ-023 SHALL fold all DAT_BYTES bytes on each accepted non-last beat in one cycle.
REQ-024 SHALL fold only bytes 0..cnt_i-1 on the last beat.
REQ-025 SHALL accept cnt_i=0 on the last beat, closing the message with no extra bytes; this allows empty messages.
REQ-026 SHALL saturate cnt_i>DAT_BYTES to DAT_BYTES.
REQ-027 SHALL register dat_o and pulse done_o exactly one cycle after the accepted last beat; latency 1.
REQ-028 SHALL set val_o together with done_o and hold it and dat_o until the next start_i, which clears val_o.
REQ-029 SHALL treat start_i in BUSY as abort-and-restart: the accumulator is re-initialised and no done_o is issued for the aborted message.
REQ-030 SHALL apply start_i in the DONE cycle after done_o: done_o still pulses and val_o clears on the next cycle.
REQ-031 SHALL treat start_i with val_i, lst_i and cnt_i=0 as a complete empty message in one beat.

Reset
REQ-032 SHALL, on rst=1, go to IDLE at once regardless of clk, including mid-message.
REQ-033 SHALL hold these reset values: done_o=0, val_o=0, dat_o=32'h0, rdy_o=1 and accumulator=0xFFFFFFFF.
REQ-034 SHALL produce no done_o for a message interrupted by reset.

Configuration
REQ-035 SHALL, with CRC32W_ADLER_EN defined, add mode_i, sampled on start_i and held for the message.
REQ-036 SHALL, with mode_i=1, compute Adler-32: A init 1, B init 0, both mod 65521, dat_o = {B,A}.
REQ-037 SHALL, with mode_i=1, apply the same cnt_i, latency and handshake rules as CRC mode.
REQ-038 SHALL, without CRC32W_ADLER_EN, compile as CRC-32 only with no mode_i port and no Adler logic.

Structure
REQ-039 SHALL place in package crc32_pkg: CRC32_POLY, CRC32_INIT, CRC32_XOROUT, ADLER_MOD=65521, and the FSM state enum.
REQ-040 SHALL use one sub-module, crc32_byte: combinational one-byte CRC update, instantiated DAT_BYTES times in a chain with cnt_i-controlled bypass.

Verification
REQ-041 SHALL test DAT_BYTES=1: "123456789" over 9 beats, lst_i on beat 9 -> dat_o=0xCBF43926 and done_o one cycle later.
REQ-042 SHALL test DAT_BYTES=4: "IEND" as one beat, cnt_i=4, lst_i -> dat_o=0xAE426082.
REQ-043 SHALL test DAT_BYTES=4: "123456789" as beats of 4, 4, 1 (cnt_i=1) -> 0xCBF43926.
REQ-044 SHALL test start_i+val_i+lst_i with cnt_i=0 -> dat_o=0x00000000, val_o=1.
REQ-045 SHALL test start_i mid-"123456789" then a full "IEND" -> only one done_o, with dat_o=0xAE426082.
REQ-046 SHALL test CRC32W_ADLER_EN, mode_i=1, "123456789" -> 0x091E01DE; also rst mid-message -> val_o=0, no done_o.
